mem_seq: RTL and testbench
==========================

Name: mem_seq

Overview:
- Parametrised memory-cycle sequencer for the PDP-8e core. It replaces the fixed-timing, single-latency memory-address path.
- The CPU state machine issues one memory operation per request: fetch, read, write, defer with auto-index, or ISZ-style increment.
- The block runs the RAM read/modify/write sequence with a configurable read latency and enforces extended-memory field limits.
- It returns data, the effective address and ISZ skip through a req/done handshake.

Parameters:
FIELD_BITS, 3, width of the extended memory address (IF/DF field)
MAX_FIELD, 7, highest populated field; higher fields are nonexistent memory
RD_LAT, 1, RAM read latency in clocks, legal 1..4

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req  in  1  start operation; accepted only when busy=0
op  in  3  0 FETCH, 1 READ, 2 WRITE, 3 DEFER, 4 INC; 5-7 treated as READ
addr_in  in  12  word address within field
field_in  in  FIELD_BITS  memory field for this operation
wdata  in  12  write data for WRITE
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse
rdata  out  12  result word, valid from done until next accept
ma  out  12  memory address register; after DEFER holds effective address
ema  out  FIELD_BITS  field of last accepted operation
skip  out  1  INC result was 0000
nxm  out  1  last operation addressed field > MAX_FIELD
ram_addr  out  FIELD_BITS+12  {ema, ma}
ram_din  out  12  RAM write data
ram_we  out  1  RAM write strobe
ram_dout  in  12  RAM read data, valid RD_LAT clocks after address presented

Behaviour:
- Reset: state IDLE; busy=0, done=0, rdata=0000, ma=0000, ema=0, skip=0, nxm=0, ram_we=0, ram_din=0000. Reset mid-operation aborts immediately; no write is issued in the reset cycle or afterwards.
- Accept (IDLE, req=1):
  - Latch addr_in->ma, field_in->ema and wdata; clear skip.
  - nxm <= (field_in > MAX_FIELD).
  - busy=1 from the next cycle. req while busy is ignored (not queued).
- States: IDLE, RD (counter 0..RD_LAT-1), MOD, WR, DONE. DONE asserts done=1, busy=0 for one cycle, then returns to IDLE. A req in the DONE cycle is accepted.
- FETCH/READ: IDLE->RD(RD_LAT)->DONE. rdata <= ram_dout at the end of RD. Latency from accept to done = RD_LAT+1.
- WRITE: IDLE->WR->DONE. In WR: ram_we=1, ram_din=wdata. Latency 2.
- INC:
  - IDLE->RD->MOD->WR->DONE.
  - MOD computes v=(read+1) mod 4096; WR writes v. rdata=v.
  - skip=1 iff read==7777, held until next accept.
- DEFER:
  - Read the pointer p.
  - If ma[0:8]==9'o001 (auto-index locations 0010-0017): MOD, then WR p+1 (wraps 7777->0000); rdata=p+1 and ma<=p+1 at DONE.
  - Otherwise go straight to DONE with rdata=p and ma<=p.
- Nonexistent field (nxm=1):
  - Reads return 0000.
  - ram_we never asserted.
  - Sequence and latency are unchanged (INC still produces 0001 and skip=0; DEFER uses p=0000).
- ram_addr is always {ema, ma}. During DEFER the write-back uses the pointer address; ma changes only at DONE.

Optional Feature:
- MEM_DBREAK_EN: adds a data-break (DMA) channel with these ports:
  - brk_req in 1
  - brk_wr in 1
  - brk_addr in 12
  - brk_field in FIELD_BITS
  - brk_wdata in 12
  - brk_done out 1
- Behaviour with MEM_DBREAK_EN defined:
  - Arbitration: in IDLE, brk_req has priority over req when both are high. The CPU req stays pending only if the requester holds it.
  - Cycle types: brk_wr=0 runs a READ; brk_wr=1 runs a WRITE, using the same latencies as the CPU ops.
  - Completion: brk_done pulses instead of done, and rdata carries the read data.
  - Preserved state: ma, ema, skip and nxm are not modified by break cycles; ram_addr uses break-private registers.
- Without the macro: the ports are absent and behaviour is as specified above.

Test Plan:
- Reset, then INC at field 0 addr 0100 holding 7777, RD_LAT=1 -> RAM 0100=0000, rdata=0000, skip=1, done 4 clocks after accept.
- DEFER at addr 0012 holding 0377 -> RAM 0012=0400, rdata=0400, ma=0400. DEFER at 0020 holding 0377 -> no write, ma=0377.
- MAX_FIELD=1; WRITE 5252 to field 2 addr 0000 -> ram_we never high, nxm=1. READ field 2 -> rdata=0000.
- RD_LAT=3: READ addr 4000 holding 1234 -> done exactly 4 clocks after accept, rdata=1234. A req pulse while busy is ignored.
- Reset asserted during WR of INC -> no ram_we, outputs at reset values, next READ works normally.
- MEM_DBREAK_EN: brk_req and req together, break write 0777 to 0200 -> brk_done first, ma unchanged. CPU op then completes with done.

Source files
------------

// File: rtl/mem_seq.sv
// Memory-cycle sequencer for the PDP-8e core: runs fetch/read/write/defer/ISZ
// RAM sequences with a configurable read latency. Define MEM_DBREAK_EN to add the data-break channel.
module mem_seq #(
  parameter int FIELD_BITS = 3,
  parameter int MAX_FIELD  = 7,
  parameter int RD_LAT     = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req,
  input  logic [2:0]               op,
  input  logic [11:0]              addr_in,
  input  logic [FIELD_BITS-1:0]    field_in,
  input  logic [11:0]              wdata,
  output logic                     busy,
  output logic                     done,
  output logic [11:0]              rdata,
  output logic [11:0]              ma,
  output logic [FIELD_BITS-1:0]    ema,
  output logic                     skip,
  output logic                     nxm,
  output logic [FIELD_BITS+11:0]   ram_addr,
  output logic [11:0]              ram_din,
  output logic                     ram_we,
  input  logic [11:0]              ram_dout
`ifdef MEM_DBREAK_EN
  ,
  input  logic                     brk_req,
  input  logic                     brk_wr,
  input  logic [11:0]              brk_addr,
  input  logic [FIELD_BITS-1:0]    brk_field,
  input  logic [11:0]              brk_wdata,
  output logic                     brk_done
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_MOD, S_WR, S_DONE} state_e;
  typedef enum logic [2:0] {
    OP_FETCH = 3'd0, OP_READ = 3'd1, OP_WRITE = 3'd2, OP_DEFER = 3'd3, OP_INC = 3'd4
  } op_e;

  localparam logic [1:0]            CNT_LAST = 2'(RD_LAT - 1);
  localparam logic [FIELD_BITS:0]   MAX_F    = (FIELD_BITS + 1)'(MAX_FIELD);

  state_e                  state_q, state_d;
  op_e                     op_q, op_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [11:0]             ma_q, ma_d;
  logic [FIELD_BITS-1:0]   ema_q, ema_d;
  logic [11:0]             wdata_q, wdata_d;
  logic [11:0]             rdata_q, rdata_d;
  logic                    skip_q, skip_d;
  logic                    nxm_q, nxm_d;
  logic                    act_nxm;
  logic                    autoidx;
  logic [11:0]             read_val;

`ifdef MEM_DBREAK_EN
  logic                    brk_q, brk_d;
  logic [11:0]             brk_addr_q, brk_addr_d;
  logic [FIELD_BITS-1:0]   brk_field_q, brk_field_d;
  logic                    brk_nxm_q, brk_nxm_d;

  assign act_nxm  = brk_q ? brk_nxm_q : nxm_q;
  assign ram_addr = brk_q ? {brk_field_q, brk_addr_q} : {ema_q, ma_q};
  assign done     = (state_q == S_DONE) && !brk_q;
  assign brk_done = (state_q == S_DONE) && brk_q;
`else
  assign act_nxm  = nxm_q;
  assign ram_addr = {ema_q, ma_q};
  assign done     = (state_q == S_DONE);
`endif

  // Auto-index locations 0010-0017 share the upper nine address bits 001.
  assign autoidx  = (ma_q[11:3] == 9'o001);
  assign read_val = act_nxm ? 12'o0000 : ram_dout;

  always_comb begin
    // NOTE: every next-state value defaults to its register first so no path infers a latch.
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    ma_d    = ma_q;
    ema_d   = ema_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    skip_d  = skip_q;
    nxm_d   = nxm_q;
`ifdef MEM_DBREAK_EN
    brk_d       = brk_q;
    brk_addr_d  = brk_addr_q;
    brk_field_d = brk_field_q;
    brk_nxm_d   = brk_nxm_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
`ifdef MEM_DBREAK_EN
        brk_d = 1'b0;
        if (brk_req) begin
          brk_d       = 1'b1;
          brk_addr_d  = brk_addr;
          brk_field_d = brk_field;
          brk_nxm_d   = ({1'b0, brk_field} > MAX_F);
          wdata_d     = brk_wdata;
          op_d        = brk_wr ? OP_WRITE : OP_READ;
          cnt_d       = 2'd0;
          state_d     = brk_wr ? S_WR : S_RD;
        end else
`endif
        if (req) begin
          ma_d    = addr_in;
          ema_d   = field_in;
          wdata_d = wdata;
          skip_d  = 1'b0;
          nxm_d   = ({1'b0, field_in} > MAX_F);
          op_d    = (op > 3'd4) ? OP_READ : op_e'(op);
          cnt_d   = 2'd0;
          state_d = (op == 3'd2) ? S_WR : S_RD;
        end
      end
      S_RD: begin
        if (cnt_q == CNT_LAST) begin
          rdata_d = read_val;
          case (op_q)
            OP_INC:   state_d = S_MOD;
            OP_DEFER: begin
              if (autoidx) begin
                state_d = S_MOD;
              end else begin
                ma_d    = read_val;
                state_d = S_DONE;
              end
            end
            default:  state_d = S_DONE;
          endcase
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_MOD: begin
        rdata_d = rdata_q + 12'o0001;
        if (op_q == OP_INC) skip_d = (rdata_q == 12'o7777);
        state_d = S_WR;
      end
      S_WR: begin
        // Deferred pointer write-back uses the pointer address; ma moves only now.
        if (op_q == OP_DEFER) ma_d = rdata_q;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_READ;
      cnt_q   <= 2'd0;
      ma_q    <= 12'o0000;
      ema_q   <= '0;
      wdata_q <= 12'o0000;
      rdata_q <= 12'o0000;
      skip_q  <= 1'b0;
      nxm_q   <= 1'b0;
`ifdef MEM_DBREAK_EN
      brk_q       <= 1'b0;
      brk_addr_q  <= 12'o0000;
      brk_field_q <= '0;
      brk_nxm_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      ma_q    <= ma_d;
      ema_q   <= ema_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      skip_q  <= skip_d;
      nxm_q   <= nxm_d;
`ifdef MEM_DBREAK_EN
      brk_q       <= brk_d;
      brk_addr_q  <= brk_addr_d;
      brk_field_q <= brk_field_d;
      brk_nxm_q   <= brk_nxm_d;
`endif
    end
  end

  // NOTE: the strobe is gated by reset combinationally so an aborted WR never reaches the RAM.
  assign ram_we  = (state_q == S_WR) && !act_nxm && !reset;
  assign ram_din = ((state_q == S_WR) && !reset) ?
                   ((op_q == OP_WRITE) ? wdata_q : rdata_q) : 12'o0000;

  assign busy  = (state_q != S_IDLE) && (state_q != S_DONE);
  assign rdata = rdata_q;
  assign ma    = ma_q;
  assign ema   = ema_q;
  assign skip  = skip_q;
  assign nxm   = nxm_q;

endmodule

// File: tb/tb_mem_seq.sv
// Self-checking bench for mem_seq: instance A (RD_LAT=1, MAX_FIELD=1) and
// instance B (RD_LAT=3, MAX_FIELD=7), each with its own RAM model.
module tb_mem_seq;
  logic        clk = 1'b0;
  logic        reset;
  logic        sel, req;
  logic [2:0]  op, field_in;
  logic [11:0] addr_in, wdata;

  always #5 clk = ~clk;

  logic        busy_a, done_a, skip_a, nxm_a, ram_we_a;
  logic        busy_b, done_b, skip_b, nxm_b, ram_we_b;
  logic [11:0] rdata_a, ma_a, ram_din_a, ram_dout_a;
  logic [11:0] rdata_b, ma_b, ram_din_b, ram_dout_b;
  logic [2:0]  ema_a, ema_b;
  logic [14:0] ram_addr_a, ram_addr_b, ap1_b, ap2_b;

`ifdef MEM_DBREAK_EN
  logic        brk_req, brk_wr, brk_done_a, brk_done_b;
  logic [11:0] brk_addr, brk_wdata;
  logic [2:0]  brk_field;
`endif

  mem_seq #(.FIELD_BITS(3), .MAX_FIELD(1), .RD_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .req(req & ~sel), .op(op), .addr_in(addr_in),
    .field_in(field_in), .wdata(wdata), .busy(busy_a), .done(done_a),
    .rdata(rdata_a), .ma(ma_a), .ema(ema_a), .skip(skip_a), .nxm(nxm_a),
    .ram_addr(ram_addr_a), .ram_din(ram_din_a), .ram_we(ram_we_a), .ram_dout(ram_dout_a)
`ifdef MEM_DBREAK_EN
    , .brk_req(brk_req), .brk_wr(brk_wr), .brk_addr(brk_addr), .brk_field(brk_field),
    .brk_wdata(brk_wdata), .brk_done(brk_done_a)
`endif
  );

  mem_seq #(.FIELD_BITS(3), .MAX_FIELD(7), .RD_LAT(3)) dut_b (
    .clk(clk), .reset(reset), .req(req & sel), .op(op), .addr_in(addr_in),
    .field_in(field_in), .wdata(wdata), .busy(busy_b), .done(done_b),
    .rdata(rdata_b), .ma(ma_b), .ema(ema_b), .skip(skip_b), .nxm(nxm_b),
    .ram_addr(ram_addr_b), .ram_din(ram_din_b), .ram_we(ram_we_b), .ram_dout(ram_dout_b)
`ifdef MEM_DBREAK_EN
    , .brk_req(1'b0), .brk_wr(brk_wr), .brk_addr(brk_addr), .brk_field(brk_field),
    .brk_wdata(brk_wdata), .brk_done(brk_done_b)
`endif
  );

  // RAM models: A reads combinationally, B presents data three clocks after the address.
  logic [11:0] mem_a [0:32767];
  logic [11:0] mem_b [0:32767];
  int we_cnt_a = 0, we_cnt_b = 0;

  always @(posedge clk) begin
    if (ram_we_a) begin
      mem_a[ram_addr_a] <= ram_din_a;
      we_cnt_a <= we_cnt_a + 1;
    end
    if (ram_we_b) begin
      mem_b[ram_addr_b] <= ram_din_b;
      we_cnt_b <= we_cnt_b + 1;
    end
    ap1_b <= ram_addr_b;
    ap2_b <= ap1_b;
  end
  assign ram_dout_a = mem_a[ram_addr_a];
  assign ram_dout_b = mem_b[ap2_b];

  logic        busy_s, done_s, skip_s, nxm_s;
  logic [11:0] rdata_s, ma_s;
  logic [2:0]  ema_s;
  assign busy_s  = sel ? busy_b  : busy_a;
  assign done_s  = sel ? done_b  : done_a;
  assign skip_s  = sel ? skip_b  : skip_a;
  assign nxm_s   = sel ? nxm_b   : nxm_a;
  assign rdata_s = sel ? rdata_b : rdata_a;
  assign ma_s    = sel ? ma_b    : ma_a;
  assign ema_s   = sel ? ema_b   : ema_a;

  int n_chk = 0, n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0o expected %0o", name, act, exp);
    end
  endtask

  task automatic start(input logic s, input logic [2:0] o, input logic [2:0] f,
                       input logic [11:0] a, input logic [11:0] w);
    @(negedge clk);
    sel = s; op = o; field_in = f; addr_in = a; wdata = w; req = 1'b1;
  endtask

  // Latency counts clock edges from the accepting edge to the one raising done.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      req = 1'b0;
      if (done_s) begin
        lat = k;
        break;
      end
    end
  endtask

  typedef struct {
    logic        s;
    logic [2:0]  o, f;
    logic [11:0] a, w;
    logic        chk_rd;
    logic [11:0] rd, ma;
    logic        skip, nxm;
    int          lat, wr;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  initial begin
    int lat, lat2, wc0, n;

    //          s     op    f     addr      wdata   chk   rdata     ma        sk    nx    lat wr
    vecs[0]  = '{1'b0, 3'd2, 3'd0, 12'o0100, 12'o7777, 1'b0, 12'o0000, 12'o0100, 1'b0, 1'b0, 2, 1};
    vecs[1]  = '{1'b0, 3'd4, 3'd0, 12'o0100, 12'o0000, 1'b1, 12'o0000, 12'o0100, 1'b1, 1'b0, 4, 1};
    vecs[2]  = '{1'b0, 3'd1, 3'd0, 12'o0100, 12'o0000, 1'b1, 12'o0000, 12'o0100, 1'b0, 1'b0, 2, 0};
    vecs[3]  = '{1'b0, 3'd2, 3'd0, 12'o0012, 12'o0377, 1'b0, 12'o0000, 12'o0012, 1'b0, 1'b0, 2, 1};
    vecs[4]  = '{1'b0, 3'd3, 3'd0, 12'o0012, 12'o0000, 1'b1, 12'o0400, 12'o0400, 1'b0, 1'b0, 4, 1};
    vecs[5]  = '{1'b0, 3'd1, 3'd0, 12'o0012, 12'o0000, 1'b1, 12'o0400, 12'o0012, 1'b0, 1'b0, 2, 0};
    vecs[6]  = '{1'b0, 3'd2, 3'd0, 12'o0020, 12'o0377, 1'b0, 12'o0000, 12'o0020, 1'b0, 1'b0, 2, 1};
    vecs[7]  = '{1'b0, 3'd3, 3'd0, 12'o0020, 12'o0000, 1'b1, 12'o0377, 12'o0377, 1'b0, 1'b0, 2, 0};
    vecs[8]  = '{1'b0, 3'd2, 3'd0, 12'o0017, 12'o7777, 1'b0, 12'o0000, 12'o0017, 1'b0, 1'b0, 2, 1};
    vecs[9]  = '{1'b0, 3'd3, 3'd0, 12'o0017, 12'o0000, 1'b1, 12'o0000, 12'o0000, 1'b0, 1'b0, 4, 1};
    vecs[10] = '{1'b0, 3'd1, 3'd0, 12'o0017, 12'o0000, 1'b1, 12'o0000, 12'o0017, 1'b0, 1'b0, 2, 0};
    vecs[11] = '{1'b0, 3'd2, 3'd1, 12'o0000, 12'o1111, 1'b0, 12'o0000, 12'o0000, 1'b0, 1'b0, 2, 1};
    vecs[12] = '{1'b0, 3'd2, 3'd2, 12'o0000, 12'o5252, 1'b0, 12'o0000, 12'o0000, 1'b0, 1'b1, 2, 0};
    vecs[13] = '{1'b0, 3'd1, 3'd2, 12'o0000, 12'o0000, 1'b1, 12'o0000, 12'o0000, 1'b0, 1'b1, 2, 0};
    vecs[14] = '{1'b0, 3'd4, 3'd2, 12'o0005, 12'o0000, 1'b1, 12'o0001, 12'o0005, 1'b0, 1'b1, 4, 0};
    vecs[15] = '{1'b0, 3'd3, 3'd2, 12'o0010, 12'o0000, 1'b1, 12'o0001, 12'o0001, 1'b0, 1'b1, 4, 0};
    vecs[16] = '{1'b0, 3'd1, 3'd1, 12'o0000, 12'o0000, 1'b1, 12'o1111, 12'o0000, 1'b0, 1'b0, 2, 0};
    vecs[17] = '{1'b0, 3'd0, 3'd0, 12'o0020, 12'o0000, 1'b1, 12'o0377, 12'o0020, 1'b0, 1'b0, 2, 0};
    vecs[18] = '{1'b0, 3'd7, 3'd0, 12'o0012, 12'o0000, 1'b1, 12'o0400, 12'o0012, 1'b0, 1'b0, 2, 0};
    vecs[19] = '{1'b0, 3'd4, 3'd0, 12'o0012, 12'o0000, 1'b1, 12'o0401, 12'o0012, 1'b0, 1'b0, 4, 1};
    vecs[20] = '{1'b1, 3'd2, 3'd0, 12'o4000, 12'o1234, 1'b0, 12'o0000, 12'o4000, 1'b0, 1'b0, 2, 1};
    vecs[21] = '{1'b1, 3'd1, 3'd0, 12'o4000, 12'o0000, 1'b1, 12'o1234, 12'o4000, 1'b0, 1'b0, 4, 0};
    vecs[22] = '{1'b1, 3'd4, 3'd0, 12'o4000, 12'o0000, 1'b1, 12'o1235, 12'o4000, 1'b0, 1'b0, 6, 1};
    vecs[23] = '{1'b1, 3'd2, 3'd7, 12'o0011, 12'o7777, 1'b0, 12'o0000, 12'o0011, 1'b0, 1'b0, 2, 1};
    vecs[24] = '{1'b1, 3'd3, 3'd7, 12'o0011, 12'o0000, 1'b1, 12'o0000, 12'o0000, 1'b0, 1'b0, 6, 1};
    vecs[25] = '{1'b1, 3'd1, 3'd7, 12'o0011, 12'o0000, 1'b1, 12'o0000, 12'o0011, 1'b0, 1'b0, 4, 0};

    reset = 1'b1; req = 1'b0; sel = 1'b0; op = 3'd0; field_in = 3'd0;
    addr_in = 12'o0000; wdata = 12'o0000;
`ifdef MEM_DBREAK_EN
    brk_req = 1'b0; brk_wr = 1'b0; brk_addr = 12'o0000; brk_field = 3'd0; brk_wdata = 12'o0000;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset busy_a", busy_a, 0);   check("reset done_a", done_a, 0);
    check("reset rdata_a", rdata_a, 0); check("reset ma_a", ma_a, 0);
    check("reset ema_a", ema_a, 0);     check("reset skip_a", skip_a, 0);
    check("reset nxm_a", nxm_a, 0);     check("reset ram_we_a", ram_we_a, 0);
    check("reset ram_din_a", ram_din_a, 0);
    check("reset busy_b", busy_b, 0);   check("reset ma_b", ma_b, 0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      wc0 = vecs[i].s ? we_cnt_b : we_cnt_a;
      start(vecs[i].s, vecs[i].o, vecs[i].f, vecs[i].a, vecs[i].w);
      wait_done(lat);
      check($sformatf("v%0d latency", i), lat, vecs[i].lat);
      if (vecs[i].chk_rd) check($sformatf("v%0d rdata", i), rdata_s, vecs[i].rd);
      check($sformatf("v%0d ma", i), ma_s, vecs[i].ma);
      check($sformatf("v%0d ema", i), ema_s, vecs[i].f);
      check($sformatf("v%0d skip", i), skip_s, vecs[i].skip);
      check($sformatf("v%0d nxm", i), nxm_s, vecs[i].nxm);
      check($sformatf("v%0d busy in done", i), busy_s, 0);
      check($sformatf("v%0d ram writes", i), (vecs[i].s ? we_cnt_b : we_cnt_a) - wc0, vecs[i].wr);
    end

    // A req pulse while busy is dropped, not queued.
    wc0 = we_cnt_b;
    start(1'b1, 3'd1, 3'd0, 12'o4000, 12'o0000);
    @(posedge clk); #1; req = 1'b0;
    @(negedge clk);
    op = 3'd2; wdata = 12'o7070; req = 1'b1;
    check("ignore busy high", busy_s, 1);
    wait_done(lat2);
    check("ignore latency", lat2 + 1, 4);
    check("ignore rdata", rdata_s, 12'o1234 + 12'o0001);
    n = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done_s || busy_s) n++;
    end
    check("ignore no extra op", n, 0);
    check("ignore no write", we_cnt_b - wc0, 0);
    start(1'b1, 3'd1, 3'd0, 12'o4000, 12'o0000);
    wait_done(lat);
    check("ignore reread", rdata_s, 12'o1235);

    // Reset landing in the WR cycle of an INC aborts it with no write.
    wc0 = we_cnt_a;
    start(1'b0, 3'd4, 3'd0, 12'o0100, 12'o0000);
    @(posedge clk); #1; req = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("rst ram_we gated", ram_we_a, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst busy", busy_a, 0);   check("rst done", done_a, 0);
    check("rst rdata", rdata_a, 0); check("rst ma", ma_a, 0);
    check("rst skip", skip_a, 0);   check("rst nxm", nxm_a, 0);
    check("rst no write", we_cnt_a - wc0, 0);
    start(1'b0, 3'd1, 3'd0, 12'o0100, 12'o0000);
    wait_done(lat);
    check("rst read latency", lat, 2);
    check("rst read rdata", rdata_a, 12'o0000);

`ifdef MEM_DBREAK_EN
    // Break and CPU request together: break wins, CPU request held completes next.
    @(negedge clk);
    sel = 1'b0; op = 3'd1; field_in = 3'd0; addr_in = 12'o0100; req = 1'b1;
    brk_req = 1'b1; brk_wr = 1'b1; brk_addr = 12'o0200; brk_field = 3'd0; brk_wdata = 12'o0777;
    lat = -1; n = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      brk_req = 1'b0;
      if (done_a) n++;
      if (brk_done_a) begin
        lat = k;
        break;
      end
    end
    check("brk write latency", lat, 2);
    check("brk no cpu done first", n, 0);
    check("brk ma unchanged", ma_a, 12'o0100);
    wait_done(lat);
    check("brk cpu latency", lat, 2);
    check("brk cpu rdata", rdata_a, 12'o0000);
    @(negedge clk);
    brk_req = 1'b1; brk_wr = 1'b0; brk_addr = 12'o0200;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      brk_req = 1'b0;
      if (brk_done_a) begin
        lat = k;
        break;
      end
    end
    check("brk read latency", lat, 2);
    check("brk read rdata", rdata_a, 12'o0777);
    check("brk read no done", done_a, 0);
    check("brk ma kept", ma_a, 12'o0100);
    check("brk done_b idle", brk_done_b, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
